// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer: access size codes,
// queued-store entry layout, fence state and the access legality rule.
package store_buffer_pkg;

    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_DEPTH = 4;

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic [2:0]       ctrl;
    } sb_entry_t;

    typedef enum logic {
        SB_RUN,
        SB_FENCE
    } sb_state_t;

    // Stores accept only signed sizes; loads also accept the unsigned variants.
    // Only the two low address bits matter for alignment.
    function automatic logic is_legal(input logic wr, input logic [2:0] ctrl,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (ctrl)
            CTRL_B:  ok = 1'b1;
            CTRL_H:  ok = (addr_lo[0] == 1'b0);
            CTRL_W:  ok = (addr_lo == 2'b00);
            CTRL_BU: ok = !wr;
            CTRL_HU: ok = !wr && (addr_lo[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side load/store signals plus the DataMemory port of the store buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             LsuReq;
    logic             LsuWr;
    logic [2:0]       LsuCtrl;
    logic [SB_AW-1:0] LsuAddr;
    logic [SB_DW-1:0] LsuDataWr;
    logic             SbFence;
    logic             LsuStall;
    logic [SB_DW-1:0] LsuDataRd;
    logic             LsuRdValid;
    logic             LsuFault;
    logic             SbFenceDone;
    logic [CW-1:0]    SbCount;
    logic [SB_AW-1:0] DMAddress;
    logic [SB_DW-1:0] DMDataWr;
    logic             DMWr;
    logic [2:0]       DMCtrl;
    logic [SB_DW-1:0] DMDataRd;

    // master: the core plus the data memory environment around the buffer
    modport master (
        output LsuReq, LsuWr, LsuCtrl, LsuAddr, LsuDataWr, SbFence, DMDataRd,
        input  LsuStall, LsuDataRd, LsuRdValid, LsuFault, SbFenceDone, SbCount,
               DMAddress, DMDataWr, DMWr, DMCtrl
    );

    modport slave (
        input  LsuReq, LsuWr, LsuCtrl, LsuAddr, LsuDataWr, SbFence, DMDataRd,
        output LsuStall, LsuDataRd, LsuRdValid, LsuFault, SbFenceDone, SbCount,
               DMAddress, DMDataWr, DMWr, DMCtrl
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// Circular queue of pending stores; every slot's word address and valid bit are
// visible so the top level can detect loads that overlap a queued store.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  sb_entry_t            push_entry,
    input  logic                 pop,
    output sb_entry_t            head,
    output logic [DEPTH-1:0]     slot_valid,
    output logic [SB_AW-3:0]     slot_word [DEPTH],
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    sb_entry_t         entries_reg [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;

    // Pointers are exactly PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            if (push) begin
                entries_reg[wr_ptr_reg] <= push_entry;
                valid_reg[wr_ptr_reg]   <= 1'b1;
                wr_ptr_reg              <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_word[gi] = entries_reg[gi].addr[SB_AW-1:2];
        end
    endgenerate

    assign head       = entries_reg[rd_ptr_reg];
    assign slot_valid = valid_reg;
    assign count      = count_reg;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores, lets non-overlapping loads take the
// memory port first, drains stores in FIFO order and implements a drain-to-empty fence.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t         state_reg;
    sb_entry_t         head;
    sb_entry_t         push_entry;
    logic [DEPTH-1:0]  slot_valid;
    logic [SB_AW-3:0]  slot_word [DEPTH];
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  hit_vec;

    logic req_ok, legal, empty, full, fencing, fence_block;
    logic is_load, is_store, load_grant, drain, enq;

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (enq),
        .push_entry (push_entry),
        .pop        (drain),
        .head       (head),
        .slot_valid (slot_valid),
        .slot_word  (slot_word),
        .count      (count)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = slot_valid[gi] && (slot_word[gi] == bus.LsuAddr[SB_AW-1:2]);
        end
    endgenerate

    assign push_entry = '{addr: bus.LsuAddr, data: bus.LsuDataWr, ctrl: bus.LsuCtrl};

    // Everything is held idle while rst is high so queued stores never reach memory.
    always_comb begin
        req_ok      = bus.LsuReq && !rst;
        legal       = is_legal(bus.LsuWr, bus.LsuCtrl, bus.LsuAddr[1:0]);
        empty       = (count == '0);
        full        = (count == CW'(DEPTH));
        fencing     = !rst && ((state_reg == SB_FENCE) || bus.SbFence);
        fence_block = fencing && !empty;
        is_load     = req_ok && legal && !bus.LsuWr;
        is_store    = req_ok && legal && bus.LsuWr;
        load_grant  = is_load && !full && !(|hit_vec) && !fence_block;
        drain       = !rst && !load_grant && !empty;
        enq         = is_store && !full && !fence_block;

        bus.LsuStall    = (is_load && !load_grant) || (is_store && !enq);
        bus.LsuFault    = req_ok && !legal;
        bus.LsuRdValid  = load_grant;
        bus.LsuDataRd   = load_grant ? bus.DMDataRd : '0;
        bus.SbFenceDone = fencing && empty;
        bus.SbCount     = count;

        bus.DMWr      = 1'b0;
        bus.DMAddress = '0;
        bus.DMDataWr  = '0;
        bus.DMCtrl    = CTRL_W;
        if (load_grant) begin
            bus.DMAddress = bus.LsuAddr;
            bus.DMCtrl    = bus.LsuCtrl;
        end else if (drain) begin
            bus.DMWr      = 1'b1;
            bus.DMAddress = head.addr;
            bus.DMDataWr  = head.data;
            bus.DMCtrl    = head.ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SB_RUN;
        end else begin
            case (state_reg)
                SB_RUN:   if (bus.SbFence && !empty) state_reg <= SB_FENCE;
                SB_FENCE: if (empty) state_reg <= SB_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer: a queue-based reference model predicts stalls,
// faults, load data and drain traffic; a byte-array DataMemory sits on the DM port.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int MEMB  = 256;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] dm_mem  [MEMB];
    logic [7:0] ref_mem [MEMB];
    logic [7:0] dm_a;
    st_t        q[$];
    bit         fence_st, last_stall, last_done;
    int         checks, errors;

    function automatic logic [31:0] load_ext(input logic [2:0] c, input logic [31:0] w);
        case (c)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // DataMemory: combinational read, byte-lane write at the clock edge
    always_comb begin
        dm_a = bus.DMAddress[7:0];
        bus.DMDataRd = load_ext(bus.DMCtrl, {dm_mem[dm_a + 8'd3], dm_mem[dm_a + 8'd2],
                                             dm_mem[dm_a + 8'd1], dm_mem[dm_a]});
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEMB; i++) dm_mem[i] <= 8'(i * 37 + 11);
        end else if (bus.DMWr) begin
            dm_mem[bus.DMAddress[7:0]] <= bus.DMDataWr[7:0];
            if (bus.DMCtrl != CTRL_B) dm_mem[bus.DMAddress[7:0] + 8'd1] <= bus.DMDataWr[15:8];
            if (bus.DMCtrl == CTRL_W) begin
                dm_mem[bus.DMAddress[7:0] + 8'd2] <= bus.DMDataWr[23:16];
                dm_mem[bus.DMAddress[7:0] + 8'd3] <= bus.DMDataWr[31:24];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int access_size(input bit wr, input logic [2:0] c);
        if (c == 3'b000 || (!wr && c == 3'b100)) return 1;
        if (c == 3'b001 || (!wr && c == 3'b101)) return 2;
        if (c == 3'b010) return 4;
        return 0;
    endfunction

    function automatic bit ref_legal(input bit wr, input logic [2:0] c, input logic [31:0] a);
        int sz;
        sz = access_size(wr, c);
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
        return load_ext(c, {ref_mem[8'(a + 3)], ref_mem[8'(a + 2)], ref_mem[8'(a + 1)], ref_mem[8'(a)]});
    endfunction

    task automatic ref_store(input st_t s);
        for (int k = 0; k < access_size(1'b1, s.ctrl); k++) ref_mem[8'(s.addr + k)] = s.data[8*k +: 8];
    endtask

    // One clock of the reference model: predict, compare at negedge, advance to next posedge.
    task automatic step(input bit in_rst);
        int cnt;
        bit legal, fencing, fblock, ld, sv, hit, grant, drain, enq, e_stall;
        logic [31:0] a;
        st_t h;
        @(negedge clk);
        cnt     = q.size();
        a       = bus.LsuAddr;
        legal   = ref_legal(bus.LsuWr, bus.LsuCtrl, a);
        fencing = !in_rst && (fence_st || bus.SbFence);
        fblock  = fencing && cnt != 0;
        ld      = !in_rst && bus.LsuReq && legal && !bus.LsuWr;
        sv      = !in_rst && bus.LsuReq && legal && bus.LsuWr;
        hit     = 1'b0;
        foreach (q[i]) if (q[i].addr / 4 == a / 4) hit = 1'b1;
        grant   = ld && cnt < DEPTH && !hit && !fblock;
        drain   = !in_rst && !grant && cnt != 0;
        enq     = sv && cnt < DEPTH && !fblock;
        e_stall = (ld && !grant) || (sv && !enq);

        check_val("sb_count", bus.SbCount, cnt);
        check_val("stall", bus.LsuStall, e_stall);
        check_val("fault", bus.LsuFault, !in_rst && bus.LsuReq && !legal);
        check_val("rd_valid", bus.LsuRdValid, grant);
        check_val("fence_done", bus.SbFenceDone, fencing && cnt == 0);
        check_val("dm_wr", bus.DMWr, drain);
        if (grant) begin
            check_val("load_data", bus.LsuDataRd, ref_load(bus.LsuCtrl, a));
            $display("%0t LD  a=%h c=%b d=%h", $time, a, bus.LsuCtrl, bus.LsuDataRd);
        end
        if (drain) begin
            h = q[0];
            check_val("drain_addr", bus.DMAddress, h.addr);
            check_val("drain_data", bus.DMDataWr, h.data);
            check_val("drain_ctrl", bus.DMCtrl, h.ctrl);
            $display("%0t WR  a=%h c=%b d=%h", $time, h.addr, h.ctrl, h.data);
            ref_store(h);
            void'(q.pop_front());
        end
        if (enq) begin
            q.push_back(st_t'{addr: a, data: bus.LsuDataWr, ctrl: bus.LsuCtrl});
            $display("%0t ST  a=%h c=%b d=%h queued", $time, a, bus.LsuCtrl, bus.LsuDataWr);
        end
        if (!in_rst && bus.LsuReq && !legal)
            $display("%0t BAD a=%h c=%b wr=%0d dropped", $time, a, bus.LsuCtrl, bus.LsuWr);
        if (in_rst) begin
            q.delete();
            fence_st = 1'b0;
        end else begin
            fence_st = fblock;
        end
        last_stall = e_stall;
        last_done  = fencing && cnt == 0;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        bus.LsuReq = 1'b1; bus.LsuWr = w; bus.LsuCtrl = c; bus.LsuAddr = a; bus.LsuDataWr = d;
        step(1'b0);
        for (int n = 0; n < 20 && last_stall; n++) step(1'b0);
        check_val("stall_bound", last_stall, 1'b0);
        bus.LsuReq = 1'b0;
    endtask

    task automatic drain_all();
        bus.LsuReq = 1'b0;
        bus.SbFence = 1'b0;
        for (int n = 0; n < 20 && q.size() != 0; n++) step(1'b0);
        check_val("drain_bound", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        fence_st = 1'b0; last_stall = 1'b0; last_done = 1'b0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'(i * 37 + 11);
        bus.LsuReq = 1'b0; bus.LsuWr = 1'b0; bus.LsuCtrl = CTRL_W;
        bus.LsuAddr = '0; bus.LsuDataWr = '0; bus.SbFence = 1'b0;
        rst = 1'b1; mem_init = 1'b1;
        step(1'b1);
        mem_init = 1'b0;
        step(1'b1);
        rst = 1'b0;

        @(negedge clk);
        check_val("rst_count", bus.SbCount, 0);
        check_val("rst_dm_ctrl", bus.DMCtrl, 3'b010);
        check_val("rst_dm_addr", bus.DMAddress, 0);
        check_val("rst_dm_data", bus.DMDataWr, 0);
        check_val("rst_rd_data", bus.LsuDataRd, 0);
        check_val("rst_stall", bus.LsuStall, 0);
        @(posedge clk); #1;

        // store followed by a non-overlapping load, then an overlapping load
        issue(1'b1, CTRL_W, 32'h10, 32'hDEADBEEF);
        issue(1'b0, CTRL_W, 32'h20, 32'h0);
        step(1'b0);
        issue(1'b1, CTRL_W, 32'h08, 32'h11223344);
        issue(1'b0, CTRL_W, 32'h08, 32'h0);
        check_val("overlap_load", bus.LsuDataRd, 32'h11223344);
        // illegal accesses
        issue(1'b0, CTRL_W, 32'h06, 32'h0);
        issue(1'b1, CTRL_H, 32'h03, 32'h5555);
        issue(1'b1, CTRL_BU, 32'h04, 32'h77);
        // fence with a queued store, then fence on an empty buffer
        issue(1'b1, CTRL_H, 32'h1A, 32'hABCD);
        bus.SbFence = 1'b1;
        issue(1'b0, CTRL_B, 32'h1B, 32'h0);
        for (int n = 0; n < 10 && !last_done; n++) step(1'b0);
        bus.SbFence = 1'b0;
        drain_all();
        bus.SbFence = 1'b1;
        step(1'b0);
        bus.SbFence = 1'b0;
        // reset with a store still queued: it must never reach memory
        issue(1'b1, CTRL_W, 32'h30, 32'hCAFEF00D);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        step(1'b0);
        check_val("rst_discard", {dm_mem[8'h33], dm_mem[8'h32], dm_mem[8'h31], dm_mem[8'h30]},
                  {ref_mem[8'h33], ref_mem[8'h32], ref_mem[8'h31], ref_mem[8'h30]});

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!last_stall) begin
                bus.LsuReq    = ($urandom_range(0, 3) != 0);
                bus.LsuWr     = $urandom_range(0, 1);
                bus.LsuCtrl   = ($urandom_range(0, 9) < 8) ? 3'(($urandom_range(0, 4) + 1) % 5 == 0 ? 2 : 0)
                                                           : 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) < 8) begin
                    case ($urandom_range(0, 4))
                        0: bus.LsuCtrl = CTRL_B;
                        1: bus.LsuCtrl = CTRL_H;
                        2: bus.LsuCtrl = CTRL_W;
                        3: bus.LsuCtrl = CTRL_BU;
                        default: bus.LsuCtrl = CTRL_HU;
                    endcase
                end
                bus.LsuAddr   = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 4) != 0) bus.LsuAddr = bus.LsuAddr & ~32'h3;
                bus.LsuDataWr = $urandom;
            end
            if (bus.SbFence && last_done) bus.SbFence = 1'b0;
            else if (!bus.SbFence && $urandom_range(0, 24) == 0) bus.SbFence = 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1; bus.LsuReq = 1'b0; bus.SbFence = 1'b0;
                step(1'b1);
                rst = 1'b0;
            end else begin
                step(1'b0);
            end
        end

        drain_all();
        for (int i = 0; i < 64; i += 4)
            check_val("mem_word", {dm_mem[i+3], dm_mem[i+2], dm_mem[i+1], dm_mem[i]},
                      {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
